// File: rtl/dds_sweep_scheduler_if.sv
// AXI4-Stream phase-increment channel between the sweep scheduler and the DDS.
// The master drives valid/data/last and the slave returns ready.
interface dds_sweep_scheduler_if #(
   parameter int PHASE_W = 32
);
   logic               tvalid;
   logic               tready;
   logic [PHASE_W-1:0] tdata;
   logic               tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/dds_sweep_scheduler.sv
// Table-driven frequency-sweep scheduler feeding the DDS phase-increment channel.
// Plays (phase, dwell) entries 0..cfg_last in order, one AXIS beat per entry,
// holding each entry for dwell+1 cycles after its beat is accepted.
// The sweep runs once, or repeats while loop_en_i is high.
// Optional build macro DDS_SWEEP_STATUS_EN adds sweep_done_o / sweep_cnt_o.
module dds_sweep_scheduler #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int PHASE_W = 32,
   parameter int DWELL_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we_i,
   input  logic [AW-1:0]      cfg_addr_i,
   input  logic [PHASE_W-1:0] cfg_phase_i,
   input  logic [DWELL_W-1:0] cfg_dwell_i,
   input  logic [AW-1:0]      cfg_last_i,
   input  logic               loop_en_i,
   input  logic               start_i,
   input  logic               stop_i,
   output logic               busy_o,
   output logic [AW-1:0]      entry_idx_o,
`ifdef DDS_SWEEP_STATUS_EN
   output logic               sweep_done_o,
   output logic [15:0]        sweep_cnt_o,
`endif
   dds_sweep_scheduler_if.master m_axis_phase
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DWELL} state_t;

   logic [PHASE_W-1:0] phase_mem [DEPTH];
   logic [DWELL_W-1:0] dwell_mem [DEPTH];

   state_t             state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [AW-1:0]      last_q, last_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [PHASE_W-1:0] tdata_q, tdata_d;
   logic               tvalid_q, tvalid_d;
   logic               tlast_q, tlast_d;
   logic               stop_pend_q, stop_pend_d;
   logic               done_d;
   logic               stop_now;

   // Table storage: writable in any state, not reset. A LOAD read of the
   // address being written in the same cycle sees the old contents.
   always_ff @(posedge clk) begin
      if (cfg_we_i) begin
         phase_mem[cfg_addr_i] <= cfg_phase_i;
         dwell_mem[cfg_addr_i] <= cfg_dwell_i;
      end
   end

   // A stop arriving on the final dwell cycle still counts for that dwell.
   assign stop_now = stop_pend_q | stop_i;

   // Next-state and output logic for the sweep FSM.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      dwell_d     = dwell_q;
      cnt_d       = cnt_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      stop_pend_d = stop_pend_q | (stop_i && (state_q != S_IDLE));
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               last_d  = cfg_last_i;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            tdata_d  = phase_mem[idx_q];
            dwell_d  = dwell_mem[idx_q];
            tvalid_d = 1'b1;
            tlast_d  = (idx_q == last_q);
            state_d  = S_SEND;
         end
         S_SEND: begin
            // Beat is held until accepted; stop never withdraws it.
            if (tvalid_q && m_axis_phase.tready) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               cnt_d    = '0;
               state_d  = S_DWELL;
            end
         end
         S_DWELL: begin
            if (cnt_q == dwell_q) begin
               if (stop_now) begin
                  stop_pend_d = 1'b0;
                  state_d     = S_IDLE;
               end else if (idx_q != last_q) begin
                  idx_d   = idx_q + AW'(1);
                  state_d = S_LOAD;
               end else begin
                  done_d = 1'b1;
                  if (loop_en_i) begin
                     idx_d   = '0;
                     state_d = S_LOAD;
                  end else begin
                     stop_pend_d = 1'b0;
                     state_d     = S_IDLE;
                  end
               end
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         last_q      <= '0;
         dwell_q     <= '0;
         cnt_q       <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         dwell_q     <= dwell_d;
         cnt_q       <= cnt_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         stop_pend_q <= stop_pend_d;
      end
   end

`ifdef DDS_SWEEP_STATUS_EN
   logic        sweep_done_q;
   logic [15:0] sweep_cnt_q;

   // Completed-sweep pulse and free-running wrap-around sweep counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         sweep_done_q <= 1'b0;
         sweep_cnt_q  <= '0;
      end else begin
         sweep_done_q <= done_d;
         if (done_d) sweep_cnt_q <= sweep_cnt_q + 16'd1;
      end
   end

   assign sweep_done_o = sweep_done_q;
   assign sweep_cnt_o  = sweep_cnt_q;
`endif

   assign busy_o              = (state_q != S_IDLE);
   assign entry_idx_o         = idx_q;
   assign m_axis_phase.tvalid = tvalid_q;
   assign m_axis_phase.tdata  = tdata_q;
   assign m_axis_phase.tlast  = tlast_q;

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Scoreboard bench for dds_sweep_scheduler: directed sweeps push expected beats
// (data, last, spacing from previous beat) and a monitor checks each handshake.
module tb_dds_sweep_scheduler;
   localparam int AW = 4, PW = 32, DW = 32;

   logic clk = 1'b0, reset = 1'b1;
   logic cfg_we = 1'b0, loop_en = 1'b0, start = 1'b0, stop = 1'b0;
   logic [AW-1:0] cfg_addr = '0, cfg_last = '0;
   logic [PW-1:0] cfg_phase = '0;
   logic [DW-1:0] cfg_dwell = '0;
   logic busy;
   logic [AW-1:0] entry_idx;
`ifdef DDS_SWEEP_STATUS_EN
   logic sweep_done;
   logic [15:0] sweep_cnt;
   int done_seen = 0;
`endif

   dds_sweep_scheduler_if #(.PHASE_W(PW)) ifc ();

   dds_sweep_scheduler #(.DEPTH(16), .AW(AW), .PHASE_W(PW), .DWELL_W(DW)) dut (
      .clk(clk), .reset(reset), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
      .cfg_phase_i(cfg_phase), .cfg_dwell_i(cfg_dwell), .cfg_last_i(cfg_last),
      .loop_en_i(loop_en), .start_i(start), .stop_i(stop), .busy_o(busy),
      .entry_idx_o(entry_idx),
`ifdef DDS_SWEEP_STATUS_EN
      .sweep_done_o(sweep_done), .sweep_cnt_o(sweep_cnt),
`endif
      .m_axis_phase(ifc.master));

   always #5 clk = ~clk;

   typedef struct { logic [PW-1:0] data; logic last; int gap; } exp_t;
   exp_t q[$];
   int cyc = 0, passed = 0, total = 0, beats = 0, last_hs = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input logic [PW-1:0] d, input logic l, input int g);
      exp_t e;
      e.data = d; e.last = l; e.gap = g;
      q.push_back(e);
   endtask

   // Monitor: handshake seen here completes on the following rising edge.
   always @(negedge clk) begin
      if (!reset && ifc.tvalid && ifc.tready) begin
         if (q.size() == 0) chk("unexpected_beat", 64'(ifc.tdata), 64'hDEAD_BEEF_DEAD_BEEF);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("beat_tdata", 64'(ifc.tdata), 64'(e.data));
            chk("beat_tlast", 64'(ifc.tlast), 64'(e.last));
            if (e.gap > 0) chk("beat_period", 64'(cyc + 1 - last_hs), 64'(e.gap));
         end
         last_hs = cyc + 1;
         beats++;
      end
   end

`ifdef DDS_SWEEP_STATUS_EN
   always @(negedge clk) begin
      if (!reset && sweep_done) begin
         done_seen++;
         chk("sweep_cnt_step", 64'(sweep_cnt), 64'(done_seen));
      end
   end
`endif

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [PW-1:0] p, input logic [DW-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_phase = p; cfg_dwell = d;
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_beats(input int n, input string name);
      int k = 0;
      while (beats < n && k < 2000) begin tick(1); k++; end
      chk(name, 64'(beats), 64'(n));
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 2000) begin tick(1); k++; end
      chk(name, 64'(busy), 64'd0);
   endtask

   initial begin
      int base, stable;
      ifc.tready = 1'b1;
      tick(3);
      reset = 1'b0;
      chk("rst_tvalid", 64'(ifc.tvalid), 0);
      chk("rst_tdata", 64'(ifc.tdata), 0);
      chk("rst_tlast", 64'(ifc.tlast), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_idx", 64'(entry_idx), 0);
`ifdef DDS_SWEEP_STATUS_EN
      chk("rst_sweep_cnt", 64'(sweep_cnt), 0);
`endif

      // Single sweep, three entries, dwell 97 -> 100-cycle beat period.
      wr(0, 32'h0051EB85, 97); wr(1, 32'h00A3D70A, 97); wr(2, 32'h00F5C28F, 97);
      cfg_last = 2; loop_en = 1'b0; base = beats;
      push(32'h0051EB85, 0, 0); push(32'h00A3D70A, 0, 100); push(32'h00F5C28F, 1, 100);
      pulse_start();
      chk("lat_load_no_valid", 64'(ifc.tvalid), 0);
      chk("lat_busy", 64'(busy), 1);
      tick(1);
      chk("lat_valid", 64'(ifc.tvalid), 1);
      wait_beats(base + 3, "single_beats");
      wait_idle("single_idle");
      chk("single_busy_fall", 64'(cyc - last_hs), 98);
      chk("single_q_empty", 64'(q.size()), 0);

      // Backpressure: beat held 20 cycles, dwell counted from the handshake.
      cfg_last = 0; ifc.tready = 1'b0; base = beats;
      pulse_start(); tick(1);
      stable = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (ifc.tvalid && ifc.tdata == 32'h0051EB85 && ifc.tlast) stable++;
      end
      chk("bp_stable", 64'(stable), 20);
      push(32'h0051EB85, 1, 0);
      ifc.tready = 1'b1;
      tick(1);
      chk("bp_valid_drop", 64'(ifc.tvalid), 0);
      wait_idle("bp_idle");
      chk("bp_dwell_after_hs", 64'(cyc - last_hs), 98);
      chk("bp_beats", 64'(beats - base), 1);

      // Loop + stop: 0,1,0,1,0 at 8-cycle period, stop mid-dwell of entry 0.
      wr(0, 32'h111, 5); wr(1, 32'h222, 5);
      cfg_last = 1; loop_en = 1'b1; base = beats;
      push(32'h111, 0, 0); push(32'h222, 1, 8); push(32'h111, 0, 8);
      push(32'h222, 1, 8); push(32'h111, 0, 8);
      pulse_start();
      wait_beats(base + 5, "loop_beats");
      tick(2);
      stop = 1'b1; tick(1); stop = 1'b0;
      wait_idle("stop_idle");
      chk("stop_at_dwell_end", 64'(cyc - last_hs), 6);
      tick(20);
      chk("stop_no_more_beats", 64'(beats - base), 5);
      loop_en = 1'b0;

      // Dwell 0 -> 3-cycle period; start+stop together stays idle.
      wr(0, 32'hAAA, 0); wr(1, 32'hBBB, 0);
      cfg_last = 1; base = beats;
      push(32'hAAA, 0, 0); push(32'hBBB, 1, 3);
      pulse_start();
      wait_beats(base + 2, "d0_beats");
      wait_idle("d0_idle");
      chk("d0_busy_fall", 64'(cyc - last_hs), 1);
      start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
      chk("ss_busy", 64'(busy), 0);
      tick(3);
      chk("ss_no_valid", 64'(ifc.tvalid), 0);

      // Live table update and start-while-busy ignored.
      wr(0, 32'h1234, 10); wr(1, 32'h5678, 10);
      cfg_last = 1; base = beats;
      push(32'h1234, 0, 0); push(32'h10000000, 1, 13);
      pulse_start();
      wait_beats(base + 1, "live_first");
      tick(2);
      wr(1, 32'h10000000, 10);
      cfg_last = 0; pulse_start(); cfg_last = 1;
      wait_idle("live_idle");
      chk("live_beats", 64'(beats - base), 2);
      chk("live_q_empty", 64'(q.size()), 0);

      // Reset while entry 1 is waiting in SEND.
      base = beats;
      push(32'h1234, 0, 0);
      pulse_start();
      wait_beats(base + 1, "rs_first");
      ifc.tready = 1'b0;
      begin
         int k = 0;
         while (!ifc.tvalid && k < 100) begin tick(1); k++; end
      end
      chk("rs_send_valid", 64'(ifc.tvalid), 1);
      chk("rs_send_idx", 64'(entry_idx), 1);
      reset = 1'b1; tick(1);
      chk("rs_tvalid", 64'(ifc.tvalid), 0);
      chk("rs_tdata", 64'(ifc.tdata), 0);
      chk("rs_busy", 64'(busy), 0);
      chk("rs_idx", 64'(entry_idx), 0);
      reset = 1'b0; ifc.tready = 1'b1;
`ifdef DDS_SWEEP_STATUS_EN
      done_seen = 0;
      chk("rs_sweep_cnt", 64'(sweep_cnt), 0);
      // Single-entry looping sweeps; fourth one is aborted by stop.
      wr(0, 32'h777, 1);
      cfg_last = 0; loop_en = 1'b1; base = beats;
      push(32'h777, 1, 0); push(32'h777, 1, 4); push(32'h777, 1, 4); push(32'h777, 1, 4);
      pulse_start();
      wait_beats(base + 4, "st_beats");
      stop = 1'b1; tick(1); stop = 1'b0;
      wait_idle("st_idle");
      loop_en = 1'b0;
      tick(3);
      chk("st_done_count", 64'(done_seen), 3);
      chk("st_sweep_cnt", 64'(sweep_cnt), 3);
`endif
      chk("final_q_empty", 64'(q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dds_sweep_scheduler.md
Name: dds_sweep_scheduler

Overview:
- Table-driven frequency-sweep scheduler for the DDS compiler phase-increment channel.
- Holds a programmable table of (phase increment, dwell) entries and plays them out in order as an AXI4-Stream master.
- Each entry's increment is held for its dwell time; sweeps run once or loop.
- Sits between the control/config logic and the DDS phase input; replaces hard-coded carrier stepping.

Parameters:
- DEPTH, 16, number of table entries.
- AW, 4, table address width; DEPTH = 2**AW.
- PHASE_W, 32, phase increment width (DDS phase channel tdata width).
- DWELL_W, 32, dwell counter width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table write address.
- cfg_phase  in  PHASE_W  phase increment to write.
- cfg_dwell  in  DWELL_W  dwell value to write.
- cfg_last  in  AW  index of the last active entry; latched at start.
- loop_en  in  1  1 = repeat sweep, 0 = single sweep; sampled at end of each sweep.
- start  in  1  start pulse; ignored while busy.
- stop  in  1  abort request; effective at end of current dwell.
- busy  out  1  high when not IDLE.
- entry_idx  out  AW  index of the entry currently loaded or playing.
- m_axis_phase_tvalid  out  1  AXIS valid.
- m_axis_phase_tready  in  1  AXIS ready.
- m_axis_phase_tdata  out  PHASE_W  phase increment.
- m_axis_phase_tlast  out  1  high on the beat carrying entry cfg_last.

Behaviour:
- Reset values: tvalid=0, tdata=0, tlast=0, busy=0, entry_idx=0, stop_pending=0, state=IDLE. Table contents are not reset.
- Table: DEPTH x (PHASE_W+DWELL_W) registers.
  - Write on cfg_we in any state.
  - Read is registered.
  - A write and a LOAD read of the same address in the same cycle return the old data.
- FSM states: IDLE, LOAD, SEND, DWELL.
- IDLE:
  - start=1 and stop=0: latch cfg_last into last_r, idx=0, busy=1, go to LOAD.
  - start and stop in the same cycle: stay in IDLE.
- LOAD (1 cycle): read table[idx] into phase_r/dwell_r, drive tdata=phase_r, tvalid=1, tlast=(idx==last_r), go to SEND.
- SEND:
  - Hold tvalid, tdata and tlast stable until tvalid&tready.
  - On handshake: tvalid=0, tlast=0, dwell counter=0, go to DWELL.
  - stop never drops tvalid before the handshake.
- DWELL:
  - Each cycle: if cnt==dwell_r, end the dwell; else cnt++.
  - DWELL therefore lasts dwell_r+1 cycles; dwell_r=0 gives 1 cycle.
  - End of dwell, in priority order:
    - stop_pending: go to IDLE, busy=0, stop_pending cleared.
    - idx!=last_r: idx++, go to LOAD.
    - idx==last_r and loop_en=1: idx=0, go to LOAD.
    - Otherwise: go to IDLE, busy=0.
- tdata retains its last value after the beat.
- stop:
  - Sets stop_pending in any non-IDLE state.
  - Ignored in IDLE.
- start while busy: ignored.
- Latency:
  - tvalid rises 2 cycles after start is sampled.
  - With tready held high, the beat-to-beat period is dwell_r+3 cycles.
- cfg_last > DEPTH-1: not possible by width. cfg_last=0 gives a single-entry sweep with tlast on every beat.
- Reset mid-operation: immediate return to reset values; tvalid may drop without a handshake. Reset overrides start.
- Counter width: dwell up to 2**DWELL_W-1; no wrap inside a dwell.

Optional Feature:
- Macro: DDS_SWEEP_STATUS_EN.
- Defined: adds outputs sweep_done (1 bit) and sweep_cnt (16 bits).
  - sweep_done pulses for 1 cycle at the end of the dwell of entry last_r, including the final non-looping sweep.
  - Aborted sweeps do not pulse.
  - sweep_cnt increments on each sweep_done, wraps at 65535->0, and resets to 0. It is not cleared by start.
- Undefined: ports and counter are absent; all other behaviour is identical.

Test Plan:
- Single sweep: write entries 0..2 = (0x51EB85,97),(0xA3D70A,97),(0xF5C28F,97); cfg_last=2, loop_en=0, tready=1, pulse start -> three beats spaced 100 cycles with those tdata values, tlast only on the third beat, busy falls 98 cycles after the third beat.
- Backpressure: tready=0 for 20 cycles after tvalid rises -> tdata/tvalid/tlast stable for 20 cycles; handshake on the cycle tready=1; dwell starts after the handshake.
- Loop + stop: 2 entries, dwell=5, loop_en=1 -> sequence 0,1,0,1 with 8-cycle period; stop asserted mid-DWELL of entry 0 -> no further beats, busy=0 at the end of that dwell.
- Edge cases: dwell=0 gives a 3-cycle period; start and stop in the same cycle leaves the block in IDLE; start while busy has no effect.
- Live update: rewrite entry 1 phase to 0x10000000 while entry 0 is dwelling -> the next beat carries 0x10000000.
- Reset in SEND with tvalid=1 -> next cycle tvalid=0, tdata=0, busy=0, entry_idx=0; with DDS_SWEEP_STATUS_EN, sweep_cnt=0 and counts 1,2,3 over three looped sweeps.
